// File: rtl/buf_32bit_unpack.sv
// Unpacks one 32-bit word per handshake into a stream of 2/4/8-bit operand lanes, LSB-first.
// Build option: define UNPACK_SIGN_EXT_EN to sign-extend narrow lanes (zero-extend otherwise).
module buf_32bit_unpack #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [3:0]        out_idx,
  output logic              out_last
);

  typedef enum logic {StEmpty, StDrain} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              drain;
  logic              last;
  logic              xfer;
  logic              accept;
  logic [1:0]        e2;
  logic [3:0]        e4;
  logic [7:0]        e8;
  logic [OUT_W-1:0]  elem;

  assign drain = (state_q == StDrain);

  // Last-element detect from the latched precision; mode_q never holds 2'b11.
  always_comb begin
    last = 1'b0;
    case (mode_q)
      2'b00:   last = (cnt_q == 4'd15);
      2'b01:   last = (cnt_q == 4'd7);
      default: last = (cnt_q == 4'd3);
    endcase
  end

  assign xfer     = drain && out_ready;
  assign in_ready = reset && (!drain || (xfer && last));
  assign accept   = in_valid && in_ready;

  always_comb begin
    e2 = hold_q[{cnt_q, 1'b0} +: 2];
    e4 = hold_q[{cnt_q[2:0], 2'b00} +: 4];
    e8 = hold_q[{cnt_q[1:0], 3'b000} +: 8];
  end

  always_comb begin
    elem = '0;
    case (mode_q)
`ifdef UNPACK_SIGN_EXT_EN
      2'b00:   elem = OUT_W'($signed(e2));
      2'b01:   elem = OUT_W'($signed(e4));
`else
      2'b00:   elem = OUT_W'(e2);
      2'b01:   elem = OUT_W'(e4);
`endif
      default: elem = OUT_W'(e8);
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StDrain;
          hold_d  = in_data;
          mode_d  = (in_mode == 2'b11) ? 2'b10 : in_mode;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (xfer) begin
          if (!last) begin
            cnt_d = cnt_q + 4'd1;
          end else if (accept) begin
            // Reload on the final beat so consecutive words stream without a bubble.
            hold_d = in_data;
            mode_d = (in_mode == 2'b11) ? 2'b10 : in_mode;
            cnt_d  = '0;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      hold_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is asserted.
  assign out_valid = reset && drain;
  assign out_data  = reset ? elem : '0;
  assign out_idx   = reset ? cnt_q : '0;
  assign out_last  = reset && drain && last;

endmodule

// File: tb/tb_buf_32bit_unpack.sv
// Self-checking bench for buf_32bit_unpack: queue-based element model plus directed literal checks.
module tb_buf_32bit_unpack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_idx;
  logic        out_last;

  buf_32bit_unpack #(.DATA_W(32), .OUT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] idx;
    logic       last;
  } elem_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] idx;
    logic       last;
    logic       rdy;
    int         cyc;
  } beat_t;

  elem_t exp_q[$];
  beat_t log_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Element k of a word, from width/count arithmetic.
  function automatic logic [7:0] elem_of(input logic [31:0] w, input logic [1:0] m, input int k);
    int wd;
    int v;
    wd = (m == 2'b00) ? 2 : (m == 2'b01) ? 4 : 8;
    v  = int'((w >> (k * wd)) & ((32'd1 << wd) - 32'd1));
`ifdef UNPACK_SIGN_EXT_EN
    if (wd < 8 && v >= (1 << (wd - 1))) v = v - (1 << wd);
`endif
    return v[7:0];
  endfunction

  function automatic int count_of(input logic [1:0] m);
    return (m == 2'b00) ? 16 : (m == 2'b01) ? 8 : 4;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: every negedge, outputs against the pending-element queue.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready),
          32'(exp_q.size() == 0 || (out_ready && exp_q.size() == 1)));
      if (exp_q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0].d));
        chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
        chk("out_last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready) begin
          log_q.push_back('{d: out_data, idx: out_idx, last: out_last, rdy: in_ready, cyc: cyc});
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < count_of(in_mode); k++) begin
          exp_q.push_back('{d: elem_of(in_data, in_mode, k), idx: 4'(k),
                            last: (k == count_of(in_mode) - 1)});
        end
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send_word(input logic [31:0] w, input logic [1:0] m);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    in_mode  = m;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_mode  = 2'b00;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 300 && log_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    if (log_q.size() < n) chk("beat_timeout", 32'(log_q.size()), 32'(n));
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: 2-bit lanes
    out_ready = 1'b1;
    log_q.delete();
    send_word(32'hE4E4E4E4, 2'b00);
    wait_beats(16);
    if (log_q.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("t1_data", 32'(log_q[i].d), 32'(i % 4));
        chk("t1_last", 32'(log_q[i].last), 32'(i == 15));
      end
      chk("t1_rdy14", 32'(log_q[14].rdy), 32'd0);
      chk("t1_rdy15", 32'(log_q[15].rdy), 32'd1);
    end

    // 2: 4-bit lanes, extension
    log_q.delete();
    send_word(32'h000000F8, 2'b01);
    wait_beats(8);
    if (log_q.size() >= 8) begin
`ifdef UNPACK_SIGN_EXT_EN
      chk("t2_b0", 32'(log_q[0].d), 32'hF8);
      chk("t2_b1", 32'(log_q[1].d), 32'hFF);
`else
      chk("t2_b0", 32'(log_q[0].d), 32'h08);
      chk("t2_b1", 32'(log_q[1].d), 32'h0F);
`endif
      for (int i = 2; i < 8; i++) chk("t2_bn", 32'(log_q[i].d), 32'h00);
    end

    // 3: backpressure at idx 2
    log_q.delete();
    out_ready = 1'b0;
    send_word(32'h80FF7F01, 2'b10);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_data", 32'(out_data), 32'hFF);
      chk("t3_hold_idx", 32'(out_idx), 32'd2);
      chk("t3_hold_rdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t3_last_data", 32'(out_data), 32'h80);
    chk("t3_last_idx", 32'(out_idx), 32'd3);
    chk("t3_last_flag", 32'(out_last), 32'd1);
    @(posedge clk);
    #1;

    // 4: back-to-back words
    log_q.delete();
    send_word(32'h04030201, 2'b10);
    send_word(32'h08070605, 2'b10);
    wait_beats(8);
    if (log_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t4_data", 32'(log_q[i].d), 32'(i + 1));
        chk("t4_nogap", 32'(log_q[i].cyc - log_q[0].cyc), 32'(i));
      end
      chk("t4_rdy_last", 32'(log_q[3].rdy), 32'd1);
    end

    // 5: reset mid-drain
    log_q.delete();
    send_word(32'hE4E4E4E4, 2'b00);
    for (int i = 0; i < 50 && !(out_valid && out_idx == 4'd5); i++) @(negedge clk);
    chk("t5_at_idx5", 32'(out_idx), 32'd5);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_idx", 32'(out_idx), 32'd0);
    chk("t5_async_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_rel_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    log_q.delete();
    send_word(32'hAABBCCDD, 2'b10);
    wait_beats(4);
    if (log_q.size() >= 4) begin
      chk("t5_first_data", 32'(log_q[0].d), 32'hDD);
      chk("t5_first_idx", 32'(log_q[0].idx), 32'd0);
    end

    // 6: reserved mode behaves as 8-bit
    log_q.delete();
    send_word(32'h11223344, 2'b11);
    wait_beats(4);
    if (log_q.size() >= 4) begin
      chk("t6_b0", 32'(log_q[0].d), 32'h44);
      chk("t6_b1", 32'(log_q[1].d), 32'h33);
      chk("t6_b2", 32'(log_q[2].d), 32'h22);
      chk("t6_b3", 32'(log_q[3].d), 32'h11);
      chk("t6_last", 32'(log_q[3].last), 32'd1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
